// File: rtl/nr_div_pkg.sv
// Shared definitions for the iterative non-restoring divider: FSM encoding,
// iteration count and parameter legality helpers.
// Latency/backpressure: n/a (package only).
package nr_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Number of RUN cycles; guarded so an illegal unroll of 0 does not divide by zero
    // before the legality check gets a chance to report it.
    function automatic int calc_iter(input int dw, input int unroll);
        return (unroll > 0) ? (dw / unroll) : 1;
    endfunction

    function automatic bit params_ok(input int dw, input int dvw, input int unroll);
        return (dw >= 2) && (dvw >= 1) && (dvw <= dw) &&
               (unroll >= 1) && ((dw % unroll) == 0);
    endfunction

endpackage

// File: rtl/nr_div_step.sv
// One combinational non-restoring division step: shift in a dividend bit, add or subtract D.
// Latency: 0 cycles (pure combinational). Backpressure: none, no handshake.
// Ports: p_in/p_out partial remainder (DVW+1 bits, two's complement), q_msb next dividend
//        bit, d divisor, q_bit retired quotient bit.
module nr_div_step
    import nr_div_pkg::*;
#(
    parameter int DVW = 8
) (
    input  logic [DVW:0]   p_in,
    input  logic           q_msb,
    input  logic [DVW-1:0] d,
    output logic [DVW:0]   p_out,
    output logic           q_bit
);

    logic [DVW:0] shifted;
    logic [DVW:0] d_ext;

    // The shifted value 2P+b may exceed the DVW+1 bit range, so the add/subtract decision
    // uses the sign of P before the shift (same sign mathematically). The result always
    // lands back in [-D, D), so modular arithmetic in DVW+1 bits yields the exact value.
    assign shifted = {p_in[DVW-1:0], q_msb};
    assign d_ext   = {1'b0, d};
    assign p_out   = p_in[DVW] ? (shifted + d_ext) : (shifted - d_ext);
    assign q_bit   = ~p_out[DVW];

endmodule

// File: rtl/nr_divider_seq.sv
// Iterative unsigned non-restoring divider, UNROLL quotient bits per clock, one op in flight.
// Latency: out_valid rises ITER+2 cycles after the accept cycle, independent of the operands.
// Backpressure: results held in DONE until out_ready; in_ready only in IDLE.
// Ports: clk, rst (sync, active high); in_valid/in_ready with dividend[DW], divisor[DVW];
//        out_valid/out_ready with quotient[DW], remainder[DVW], div_zero.
module nr_divider_seq
    import nr_div_pkg::*;
#(
    parameter int DW     = 8,
    parameter int DVW    = 8,
    parameter int UNROLL = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  dividend,
    input  logic [DVW-1:0] divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  quotient,
    output logic [DVW-1:0] remainder,
    output logic           div_zero
);

    localparam int ITER = calc_iter(DW, UNROLL);
    localparam int CW   = $clog2(ITER + 1);

    generate
        if (!params_ok(DW, DVW, UNROLL)) begin : g_bad_params
            $error("nr_divider_seq: illegal DW/DVW/UNROLL combination");
        end
    endgenerate

    state_t         state_q;
    state_t         state_d;
    logic [CW-1:0]  cnt_q;
    logic [DVW:0]   p_q;
    logic [DW-1:0]  q_q;
    logic [DVW-1:0] d_q;
    logic [DVW-1:0] dvd_lo_q;   // dividend low bits, q_q is shifted away during RUN
    logic           accept;
    logic           cnt_last;
    logic [DVW-1:0] rem_fix;

    logic [UNROLL:0][DVW:0] p_chain;
    logic [UNROLL:0][DW-1:0] q_chain;
    logic [UNROLL-1:0]      q_bits;

    assign p_chain[0] = p_q;
    assign q_chain[0] = q_q;

    generate
        for (genvar i = 0; i < UNROLL; i++) begin : g_step
            nr_div_step #(.DVW(DVW)) u_step (
                .p_in  (p_chain[i]),
                .q_msb (q_chain[i][DW-1]),
                .d     (d_q),
                .p_out (p_chain[i+1]),
                .q_bit (q_bits[i])
            );
            assign q_chain[i+1] = {q_chain[i][DW-2:0], q_bits[i]};
        end
    endgenerate

    assign cnt_last = (cnt_q == CW'(ITER - 1));

    // Final correction; the corrected value lies in [0, D) so the low DVW bits suffice.
    assign rem_fix = p_q[DVW] ? (p_q[DVW-1:0] + d_q) : p_q[DVW-1:0];

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_last) state_d = FIX;
            end
            FIX: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            p_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            dvd_lo_q  <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                p_q      <= '0;
                q_q      <= dividend;
                d_q      <= divisor;
                dvd_lo_q <= dividend[DVW-1:0];
                cnt_q    <= '0;
            end
            if (state_q == RUN) begin
                p_q   <= p_chain[UNROLL];
                q_q   <= q_chain[UNROLL];
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == FIX) begin
                if (d_q == '0) begin
                    // Datapath result is meaningless for a zero divisor; report a fixed pattern.
                    quotient  <= '1;
                    remainder <= dvd_lo_q;
                    div_zero  <= 1'b1;
                end else begin
                    quotient  <= q_q;
                    remainder <= rem_fix;
                    div_zero  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_nr_divider_seq.sv
// Scoreboard bench for nr_divider_seq: default instance (8/8, UNROLL=1) and a 16/8 UNROLL=4 instance.
// Latency: n/a. Backpressure: exercises held out_ready and random out_ready.
module tb_nr_divider_seq;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          acc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    bit   rand_rdy;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, div_zero1;
    logic [7:0]  dividend1, divisor1, quotient1, remainder1;
    logic        in_valid2, in_ready2, out_valid2, out_ready2, div_zero2;
    logic [15:0] dividend2, quotient2;
    logic [7:0]  divisor2, remainder2;

    exp_t exp1[$];
    exp_t exp2[$];
    logic ov1_d, ov2_d;

    nr_divider_seq dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .dividend(dividend1), .divisor(divisor1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .quotient(quotient1), .remainder(remainder1), .div_zero(div_zero1)
    );

    nr_divider_seq #(.DW(16), .DVW(8), .UNROLL(4)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .dividend(dividend2), .divisor(divisor2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .quotient(quotient2), .remainder(remainder2), .div_zero(div_zero2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the 8-bit instance: latency on the rising edge of out_valid, data every
    // valid cycle (covers stability while stalled), pop on handshake.
    always @(negedge clk) begin
        if (rst) begin
            ov1_d = 1'b0;
        end else begin
            if (out_valid1) begin
                if (exp1.size() == 0) begin
                    chk("spurious_out1", 1, 0);
                end else begin
                    if (!ov1_d) chk("latency1", cyc - exp1[0].acc, 10);
                    chk("quotient1", {24'd0, quotient1}, {16'd0, exp1[0].q});
                    chk("remainder1", {24'd0, remainder1}, {24'd0, exp1[0].r});
                    chk("div_zero1", {31'd0, div_zero1}, {31'd0, exp1[0].dz});
                    chk("in_ready1_busy", {31'd0, in_ready1}, 0);
                    if (out_ready1) void'(exp1.pop_front());
                end
            end
            ov1_d = out_valid1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            ov2_d = 1'b0;
        end else begin
            if (out_valid2) begin
                if (exp2.size() == 0) begin
                    chk("spurious_out2", 1, 0);
                end else begin
                    if (!ov2_d) chk("latency2", cyc - exp2[0].acc, 6);
                    chk("quotient2", {16'd0, quotient2}, {16'd0, exp2[0].q});
                    chk("remainder2", {24'd0, remainder2}, {24'd0, exp2[0].r});
                    chk("div_zero2", {31'd0, div_zero2}, {31'd0, exp2[0].dz});
                    if (out_ready2) void'(exp2.pop_front());
                end
            end
            ov2_d = out_valid2;
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready2 = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic send1(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] q, input logic [7:0] r, input logic dz, input bit push);
        exp_t e;
        dividend1 = a;
        divisor1  = b;
        in_valid1 = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready1) break;
        end
        if (!in_ready1) begin
            chk("accept1_timeout", 0, 1);
        end else if (push) begin
            e.q = {8'd0, q}; e.r = r; e.dz = dz; e.acc = cyc;
            exp1.push_back(e);
        end
        @(posedge clk);
        #1 in_valid1 = 1'b0;
    endtask

    task automatic send2(input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] q, input logic [7:0] r, input logic dz);
        exp_t e;
        dividend2 = a;
        divisor2  = b;
        in_valid2 = 1'b1;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (in_ready2) break;
        end
        if (!in_ready2) begin
            chk("accept2_timeout", 0, 1);
        end else begin
            e.q = q; e.r = r; e.dz = dz; e.acc = cyc;
            exp2.push_back(e);
        end
        @(posedge clk);
        #1 in_valid2 = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && (exp1.size() != 0 || exp2.size() != 0); t++)
            @(posedge clk);
        #1;
        chk("drain_q1_empty", exp1.size(), 0);
        chk("drain_q2_empty", exp2.size(), 0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        checks = 0; errors = 0; rand_rdy = 1'b0;
        rst = 1'b1;
        in_valid1 = 0; dividend1 = 0; divisor1 = 0; out_ready1 = 1'b1;
        in_valid2 = 0; dividend2 = 0; divisor2 = 0; out_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready1}, 1);
        chk("rst_out_valid", {31'd0, out_valid1}, 0);
        chk("rst_quotient", {24'd0, quotient1}, 0);
        chk("rst_remainder", {24'd0, remainder1}, 0);
        chk("rst_div_zero", {31'd0, div_zero1}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed vectors, 8/8 UNROLL=1
        send1(100, 7, 14, 2, 0, 1);
        send1(255, 1, 255, 0, 0, 1);
        send1(3, 10, 0, 3, 0, 1);
        send1(200, 200, 1, 0, 0, 1);
        send1(255, 255, 1, 0, 0, 1);
        send1(5, 0, 8'hFF, 5, 1, 1);
        drain();

        // Stall the result: outputs must hold, no new accept during DONE
        out_ready1 = 1'b0;
        send1(37, 6, 6, 1, 0, 1);
        for (int t = 0; t < 50 && !out_valid1; t++) @(negedge clk);
        chk("stall_out_valid", {31'd0, out_valid1}, 1);
        dividend1 = 20; divisor1 = 3; in_valid1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready1}, 0);
            chk("stall_valid_held", {31'd0, out_valid1}, 1);
        end
        @(posedge clk);
        #1 out_ready1 = 1'b1;
        send1(20, 3, 6, 2, 0, 1);
        drain();

        // Reset in the 4th RUN cycle discards the operation
        send1(100, 7, 14, 2, 0, 0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrun_rst_in_ready", {31'd0, in_ready1}, 1);
        chk("midrun_rst_out_valid", {31'd0, out_valid1}, 0);
        @(posedge clk);
        #1;
        send1(100, 7, 14, 2, 0, 1);
        drain();

        // 16/8 UNROLL=4 instance
        send2(16'd60000, 8'd255, 16'd235, 8'd75, 1'b0);
        send2(16'd1234, 8'd0, 16'hFFFF, 8'd210, 1'b1);
        send2(16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0);
        send2(16'd7, 8'd200, 16'd0, 8'd7, 1'b0);
        send2(16'd1000, 8'd16, 16'd62, 8'd8, 1'b0);
        drain();

        // Back-to-back with random out_ready against integer division
        rand_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 8'($urandom_range(0, 255));
            if (rb == 0)
                send2(ra, rb, 16'hFFFF, ra[7:0], 1'b1);
            else
                send2(ra, rb, ra / {8'd0, rb}, 8'(ra % {8'd0, rb}), 1'b0);
        end
        drain();
        rand_rdy = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
